// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM stage: branch resolve, req/ack data access, MEM/WB register
// Optional bus timeout abort enabled by defining MEM_TIMEOUT_EN.
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        branch_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [1:0]  mem_to_reg_in,
    input  logic        reg_write_in,
    input  logic [31:0] jmp_addr,
    input  logic        z_in,
    input  logic [31:0] pc_value_in,
    input  logic [31:0] result_in,
    input  logic [31:0] rt_in,
    input  logic [4:0]  reg_dst_in,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic        stall,
    output logic        pc_src,
    output logic [31:0] branch_target,
    output logic        reg_write_out,
    output logic [1:0]  mem_to_reg_out,
    output logic [31:0] read_data_out,
    output logic [31:0] result_out,
    output logic [31:0] pc_value_out,
    output logic [4:0]  reg_dst_out,
    output logic        misalign_out,
    output logic        bus_error
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0] state;
    logic       is_mem;
    logic       access;
    logic       misaligned;
    logic       tc;

    assign is_mem     = mem_read_in | mem_write_in;
    assign access     = is_mem & (result_in[1:0] == 2'b00);
    assign misaligned = is_mem & (result_in[1:0] != 2'b00);

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] tmo_count;

    // Terminal count: this is the TIMEOUT_CYCLES-th WAIT cycle without ack.
    assign tc = (state == S_WAIT) & ~dmem_ack & (tmo_count == TMO_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tmo_count <= 8'd0;
        end else if (state == S_IDLE) begin
            tmo_count <= 8'd0;
        end else if (!dmem_ack) begin
            tmo_count <= tmo_count + 8'd1;
        end
    end
`else
    assign tc = 1'b0;
`endif

    assign stall         = (state == S_IDLE) ? access : (~dmem_ack & ~tc);
    assign pc_src        = branch_in & z_in;
    assign branch_target = jmp_addr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= 32'd0;
            dmem_wdata     <= 32'd0;
            reg_write_out  <= 1'b0;
            mem_to_reg_out <= 2'd0;
            read_data_out  <= 32'd0;
            result_out     <= 32'd0;
            pc_value_out   <= 32'd0;
            reg_dst_out    <= 5'd0;
            misalign_out   <= 1'b0;
            bus_error      <= 1'b0;
        end else begin
            misalign_out <= 1'b0;
            bus_error    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (access) begin
                        state          <= S_WAIT;
                        dmem_req       <= 1'b1;
                        dmem_we        <= mem_write_in & ~mem_read_in;
                        dmem_addr      <= result_in;
                        dmem_wdata     <= rt_in;
                        reg_write_out  <= 1'b0;
                        mem_to_reg_out <= 2'd0;
                    end else begin
                        // Misaligned accesses pass through as a bubble with the flag raised.
                        reg_write_out  <= reg_write_in & ~misaligned;
                        mem_to_reg_out <= misaligned ? 2'd0 : mem_to_reg_in;
                        read_data_out  <= 32'd0;
                        result_out     <= result_in;
                        pc_value_out   <= pc_value_in;
                        reg_dst_out    <= reg_dst_in;
                        misalign_out   <= misaligned;
                    end
                end
                S_WAIT: begin
                    if (dmem_ack) begin
                        state          <= S_IDLE;
                        dmem_req       <= 1'b0;
                        dmem_we        <= 1'b0;
                        reg_write_out  <= reg_write_in;
                        mem_to_reg_out <= mem_to_reg_in;
                        read_data_out  <= dmem_we ? 32'd0 : dmem_rdata;
                        result_out     <= result_in;
                        pc_value_out   <= pc_value_in;
                        reg_dst_out    <= reg_dst_in;
                    end else if (tc) begin
                        state          <= S_IDLE;
                        dmem_req       <= 1'b0;
                        dmem_we        <= 1'b0;
                        reg_write_out  <= 1'b0;
                        mem_to_reg_out <= 2'd0;
                        read_data_out  <= 32'd0;
                        bus_error      <= 1'b1;
                    end else begin
                        reg_write_out  <= 1'b0;
                        mem_to_reg_out <= 2'd0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
